uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 31 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line state encoding used by both receiver and
// transmitter, plus the default bit period for a 100 MHz / 115200 baud link.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bundle: byte, its strobe, framing-error strobe, busy flag
// and the FSM state for observation.
interface uart_rx_if;
  import uart_pkg::*;

  // o_valid and o_frame_err are single-cycle strobes with no back-pressure:
  // the consumer must capture o_data in the cycle o_valid is high. o_data is
  // stable between strobes. The two strobes are mutually exclusive.
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_busy;
  uart_state_t state;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy,
    output state
  );

  modport slave (
    input o_data,
    input o_valid,
    input o_frame_err,
    input o_busy,
    input state
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset level is a
// parameter so an idle-high line comes out of reset already idle.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling driven by a baud counter restarted at
// the falling start edge, with glitch rejection and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_rx,
  uart_rx_if.master rx_if
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_rx),
    .o_q    (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end

      // Re-check the line half a bit in: a short low glitch is dropped here.
      ST_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A low stop bit may be a break; wait for the line to recover before
      // looking for another start edge.
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = ferr_q;
  assign rx_if.o_busy      = (state_q != ST_IDLE);
  assign rx_if.state       = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed framing cases plus random bytes,
// at 16 clocks per bit and at 4 clocks per bit with skewed line timing.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_T  = 100;
  localparam int BIT16  = 16 * CLK_T;
  localparam int BIT4   = 4 * CLK_T;

  logic clk;
  logic rst_n;
  logic rx16;
  logic rx4;

  uart_rx_if if16 ();
  uart_rx_if if4 ();

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_rx   (rx16),
    .rx_if  (if16)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_rx   (rx4),
    .rx_if  (if4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #(CLK_T / 2) clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q16[$];
  logic [7:0] exp_q4[$];
  logic [7:0] last16;
  logic [7:0] last4;
  int n_checks;
  int n_fail;
  int n_valid16, n_ferr16, n_valid4, n_ferr4;
  int exp_valid16, exp_ferr16, exp_valid4;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    n_valid16   = 0;
    n_ferr16    = 0;
    n_valid4    = 0;
    n_ferr4     = 0;
    exp_valid16 = 0;
    exp_ferr16  = 0;
    exp_valid4  = 0;
    last16      = 8'h00;
    last4       = 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitors: every strobe is matched against the expected-byte queue.
  always @(negedge clk) begin
    if (if16.o_valid || if16.o_frame_err)
      check("excl16", 32'(if16.o_valid & if16.o_frame_err), 32'd0);
    if (if16.o_valid) begin
      n_valid16++;
      check("valid16_expected", 32'(exp_q16.size() > 0), 32'd1);
      if (exp_q16.size() > 0) check("data16", 32'(if16.o_data), 32'(exp_q16.pop_front()));
    end
    if (if16.o_frame_err) n_ferr16++;
  end

  always @(negedge clk) begin
    if (if4.o_valid || if4.o_frame_err)
      check("excl4", 32'(if4.o_valid & if4.o_frame_err), 32'd0);
    if (if4.o_valid) begin
      n_valid4++;
      check("valid4_expected", 32'(exp_q4.size() > 0), 32'd1);
      if (exp_q4.size() > 0) check("data4", 32'(if4.o_data), 32'(exp_q4.pop_front()));
    end
    if (if4.o_frame_err) n_ferr4++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel4, input logic v);
    if (sel4) rx4 = v;
    else      rx16 = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align();
    @(posedge clk);
    #75;
  endtask

  // Reference rule: a frame whose stop bit is high yields its byte; a low
  // stop bit yields one framing error and leaves the last good byte in place.
  task automatic send_frame(input bit sel4, input logic [7:0] b, input bit stop_ok,
                            input int bit_t);
    if (stop_ok) begin
      if (sel4) begin
        exp_q4.push_back(b);
        last4 = b;
        exp_valid4++;
      end else begin
        exp_q16.push_back(b);
        last16 = b;
        exp_valid16++;
      end
    end else if (!sel4) begin
      exp_ferr16++;
    end
    drive(sel4, 1'b0);
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      drive(sel4, b[i]);
      #(bit_t);
    end
    drive(sel4, stop_ok);
    #(bit_t);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] a5;
    logic [7:0] rb;
    int         skew_t;

    rst_n = 1'b0;
    rx16  = 1'b1;
    rx4   = 1'b1;
    a5    = 8'hA5;

    // Reset state
    wait_cycles(5);
    check("rst_data",  32'(if16.o_data), 32'h00);
    check("rst_valid", 32'(if16.o_valid), 32'd0);
    check("rst_ferr",  32'(if16.o_frame_err), 32'd0);
    check("rst_busy",  32'(if16.o_busy), 32'd0);
    check("rst_state", 32'(if16.state), 32'(ST_IDLE));
    rst_n = 1'b1;
    wait_cycles(4);

    // Single correct byte
    align();
    send_frame(1'b0, 8'h31, 1'b1, BIT16);
    wait_cycles(4);
    check("b31_data",  32'(if16.o_data), 32'h31);
    check("b31_count", 32'(n_valid16), 32'(exp_valid16));
    check("b31_ferr",  32'(n_ferr16), 32'd0);

    // "Hi" back-to-back, no idle gap
    align();
    send_frame(1'b0, 8'h48, 1'b1, BIT16);
    send_frame(1'b0, 8'h69, 1'b1, BIT16);
    wait_cycles(4);
    check("hi_count", 32'(n_valid16), 32'(exp_valid16));
    check("hi_data",  32'(if16.o_data), 32'h69);

    // Short low glitch is rejected
    align();
    rx16 = 1'b0;
    #(4 * CLK_T);
    check("glitch_busy_hi", 32'(if16.o_busy), 32'd1);
    rx16 = 1'b1;
    wait_cycles(40);
    check("glitch_valid", 32'(n_valid16), 32'(exp_valid16));
    check("glitch_ferr",  32'(n_ferr16), 32'(exp_ferr16));
    check("glitch_busy",  32'(if16.o_busy), 32'd0);
    check("glitch_state", 32'(if16.state), 32'(ST_IDLE));

    // Low stop bit followed by a held-low line (break)
    align();
    send_frame(1'b0, 8'h55, 1'b0, BIT16);
    #(100 * CLK_T);
    wait_cycles(1);
    check("brk_ferr",  32'(n_ferr16), 32'(exp_ferr16));
    check("brk_valid", 32'(n_valid16), 32'(exp_valid16));
    check("brk_data",  32'(if16.o_data), 32'(last16));
    check("brk_busy",  32'(if16.o_busy), 32'd1);
    check("brk_state", 32'(if16.state), 32'(ST_WAIT_HIGH));
    rx16 = 1'b1;
    wait_cycles(5);
    check("brk_release_busy", 32'(if16.o_busy), 32'd0);
    check("brk_ferr_once",    32'(n_ferr16), 32'(exp_ferr16));

    // Reset in the middle of bit 4 of 0xA5, held until the line is idle
    align();
    rx16 = 1'b0;
    #(BIT16);
    for (int i = 0; i < 4; i++) begin
      rx16 = a5[i];
      #(BIT16);
    end
    rx16 = a5[4];
    #(BIT16 / 2);
    rst_n = 1'b0;
    #(BIT16 / 2);
    for (int i = 5; i < 8; i++) begin
      rx16 = a5[i];
      #(BIT16);
    end
    rx16 = 1'b1;
    #(2 * BIT16);
    wait_cycles(1);
    check("midrst_busy", 32'(if16.o_busy), 32'd0);
    check("midrst_data", 32'(if16.o_data), 32'h00);
    last16 = 8'h00;
    last4  = 8'h00;
    rst_n  = 1'b1;
    wait_cycles(4);
    check("midrst_no_pulse", 32'(n_valid16), 32'(exp_valid16));
    align();
    send_frame(1'b0, 8'h0F, 1'b1, BIT16);
    wait_cycles(4);
    check("after_rst_data", 32'(if16.o_data), 32'h0F);

    // Random bytes with random idle gaps (including none)
    align();
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(1'b0, rb, 1'b1, BIT16);
      #($urandom_range(0, 3) * BIT16 + $urandom_range(0, 99));
    end
    wait_cycles(4);
    check("rand16_data",  32'(if16.o_data), 32'(last16));
    check("rand16_count", 32'(n_valid16), 32'(exp_valid16));
    check("rand16_drain", 32'(exp_q16.size()), 32'd0);

    // 4 clocks per bit with +/-3% line skew
    align();
    send_frame(1'b1, 8'h31, 1'b1, BIT4 + 12);
    wait_cycles(4);
    check("skew_slow_data", 32'(if4.o_data), 32'h31);
    align();
    send_frame(1'b1, 8'hCE, 1'b1, BIT4 - 12);
    wait_cycles(4);
    check("skew_fast_data", 32'(if4.o_data), 32'hCE);
    for (int k = 0; k < 10; k++) begin
      rb = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       skew_t = BIT4 - 12;
        1:       skew_t = BIT4;
        default: skew_t = BIT4 + 12;
      endcase
      align();
      send_frame(1'b1, rb, 1'b1, skew_t);
    end
    wait_cycles(4);
    check("rand4_data",  32'(if4.o_data), 32'(last4));
    check("rand4_count", 32'(n_valid4), 32'(exp_valid4));
    check("rand4_ferr",  32'(n_ferr4), 32'd0);
    check("rand4_drain", 32'(exp_q4.size()), 32'd0);

    // Final report
    check("final16_ferr", 32'(n_ferr16), 32'(exp_ferr16));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
